// File: rtl/pwm_bank_pkg.sv
// Register-map helpers shared by the PWM LED bank and its channel slices.
// Word offsets are expressed in terms of the channel count C.
package pwm_bank_pkg;

   localparam int CTRL_EN_BIT = 0;

   function automatic int CUR_IDX(input int i);
      return i;
   endfunction

   function automatic int SAV_IDX(input int c, input int i);
      return c + i;
   endfunction

   function automatic int CTRL_IDX(input int c);
      return 2 * c;
   endfunction

   function automatic int TOP_IDX(input int c);
      return 2 * c + 1;
   endfunction

endpackage

// File: rtl/pwm_bank_channel.sv
// One PWM channel: double-buffered active duty, compare against the shared
// period counter, and a registered output with selectable polarity.
module pwm_bank_channel
   import pwm_bank_pkg::*;
#(
   parameter int DUTY_WIDTH = 8,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic                  fast_clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  load,
   input  logic [DUTY_WIDTH-1:0] duty_in,
   input  logic [DUTY_WIDTH-1:0] pcnt,
   output logic                  pwm_out
);

   logic [DUTY_WIDTH-1:0] duty_q, duty_d;
   logic                  pwm_q, pwm_d;

   always_comb begin
      duty_d = duty_q;
      if (load) begin
         duty_d = duty_in;
      end
      // Compare uses the duty in force before this edge, so a reload never glitches.
      pwm_d = (en & (pcnt < duty_q)) ^ ACTIVE_LOW;
   end

   always_ff @(posedge fast_clk or posedge rst) begin
      if (rst) begin
         duty_q <= '0;
         pwm_q  <= ACTIVE_LOW;
      end else begin
         duty_q <= duty_d;
         pwm_q  <= pwm_d;
      end
   end

   assign pwm_out = pwm_q;

endmodule

// File: rtl/pwm_led_bank.sv
// Memory-mapped bank of PWM channels with current/saved duty sets, shared
// prescaler and period counter, and period-boundary double buffering.
module pwm_led_bank
   import pwm_bank_pkg::*;
#(
   parameter int                  CHANNELS    = 6,
   parameter int                  DUTY_WIDTH  = 8,
   parameter int                  PRESCALE    = 1,
   parameter logic [DUTY_WIDTH-1:0] TOP_DEFAULT = DUTY_WIDTH'(8'hff),
   parameter bit                  ACTIVE_LOW  = 1'b0,
   parameter int                  ADDR_WIDTH  = 6
) (
   input  logic                  fast_clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic                  rd_en,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [31:0]           wr_data,
   output logic [31:0]           rd_data,
   input  logic                  sel_saved,
   output logic [CHANNELS-1:0]   pwm_out,
   output logic                  period_strobe
);

   localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

   logic [DUTY_WIDTH-1:0] cur_q [CHANNELS];
   logic [DUTY_WIDTH-1:0] cur_d [CHANNELS];
   logic [DUTY_WIDTH-1:0] sav_q [CHANNELS];
   logic [DUTY_WIDTH-1:0] sav_d [CHANNELS];
   logic [DUTY_WIDTH-1:0] top_q, top_d;
   logic [DUTY_WIDTH-1:0] atop_q, atop_d;
   logic [DUTY_WIDTH-1:0] pcnt_q, pcnt_d;
   logic [PSC_W-1:0]      psc_q, psc_d;
   logic                  en_q, en_d;
   logic                  sync1_q, sync1_d;
   logic                  sel_s_q, sel_s_d;
   logic                  strobe_q, strobe_d;
   logic [31:0]           rd_data_q, rd_data_d;
   logic [31:0]           rd_val;
   logic                  tick, wrap, load;
   int                    addr_i;
   logic                  unused_wr_hi;

   assign addr_i       = int'(addr);
   assign unused_wr_hi = &{1'b0, wr_data[31:DUTY_WIDTH]};

   always_comb begin
      sync1_d  = sel_saved;
      sel_s_d  = sync1_q;
      tick     = en_q && (psc_q == PSC_W'(PRESCALE - 1));
      wrap     = tick && (pcnt_q == atop_q);
      // While disabled the active set tracks the registers, so enabling starts fresh.
      load     = wrap || !en_q;
      strobe_d = wrap;
      atop_d   = load ? top_q : atop_q;
      psc_d    = '0;
      pcnt_d   = '0;
      if (en_q) begin
         psc_d  = tick ? '0 : psc_q + 1'b1;
         pcnt_d = pcnt_q;
         if (tick) begin
            pcnt_d = wrap ? '0 : pcnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      cur_d  = cur_q;
      sav_d  = sav_q;
      top_d  = top_q;
      en_d   = en_q;
      rd_val = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (addr_i == CUR_IDX(i)) begin
            rd_val = 32'(cur_q[i]);
            if (wr_en) cur_d[i] = wr_data[DUTY_WIDTH-1:0];
         end
         if (addr_i == SAV_IDX(CHANNELS, i)) begin
            rd_val = 32'(sav_q[i]);
            if (wr_en) sav_d[i] = wr_data[DUTY_WIDTH-1:0];
         end
      end
      if (addr_i == CTRL_IDX(CHANNELS)) begin
         rd_val = 32'(en_q);
         if (wr_en) en_d = wr_data[CTRL_EN_BIT];
      end
      if (addr_i == TOP_IDX(CHANNELS)) begin
         rd_val = 32'(top_q);
         if (wr_en) top_d = wr_data[DUTY_WIDTH-1:0];
      end
      // rd_val is built from pre-edge state, so a same-cycle write reads the old value.
      rd_data_d = rd_en ? rd_val : rd_data_q;
   end

   always_ff @(posedge fast_clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < CHANNELS; i++) begin
            cur_q[i] <= '0;
            sav_q[i] <= '0;
         end
         top_q     <= TOP_DEFAULT;
         atop_q    <= TOP_DEFAULT;
         en_q      <= 1'b1;
         pcnt_q    <= '0;
         psc_q     <= '0;
         sync1_q   <= 1'b0;
         sel_s_q   <= 1'b0;
         strobe_q  <= 1'b0;
         rd_data_q <= '0;
      end else begin
         cur_q     <= cur_d;
         sav_q     <= sav_d;
         top_q     <= top_d;
         atop_q    <= atop_d;
         en_q      <= en_d;
         pcnt_q    <= pcnt_d;
         psc_q     <= psc_d;
         sync1_q   <= sync1_d;
         sel_s_q   <= sel_s_d;
         strobe_q  <= strobe_d;
         rd_data_q <= rd_data_d;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic [DUTY_WIDTH-1:0] duty_sel;
      assign duty_sel = sel_s_q ? sav_q[g] : cur_q[g];

      pwm_bank_channel #(
         .DUTY_WIDTH (DUTY_WIDTH),
         .ACTIVE_LOW (ACTIVE_LOW)
      ) u_ch (
         .fast_clk (fast_clk),
         .rst      (rst),
         .en       (en_q),
         .load     (load),
         .duty_in  (duty_sel),
         .pcnt     (pcnt_q),
         .pwm_out  (pwm_out[g])
      );
   end

   assign rd_data       = rd_data_q;
   assign period_strobe = strobe_q;

endmodule

// File: tb/tb_pwm_led_bank.sv
// Bench for pwm_led_bank: a period-level reference model checked every cycle
// plus directed scenarios with literal expected patterns.
module tb_pwm_led_bank;

   localparam int C     = 6;
   localparam int DW    = 8;
   localparam int PRESC = 1;

   logic          fast_clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_en = 1'b0;
   logic          rd_en = 1'b0;
   logic          sel_saved = 1'b0;
   logic [5:0]    addr = '0;
   logic [31:0]   wr_data = '0;
   logic [31:0]   rd_a, rd_b;
   logic [C-1:0]  pwm_a, pwm_b;
   logic          strobe_a, strobe_b;

   int checks = 0;
   int errors = 0;

   always #5 fast_clk = ~fast_clk;

   pwm_led_bank #(.CHANNELS(C), .DUTY_WIDTH(DW), .PRESCALE(PRESC), .TOP_DEFAULT(8'hff),
                  .ACTIVE_LOW(1'b0), .ADDR_WIDTH(6)) dut_a (
      .fast_clk(fast_clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_a), .sel_saved(sel_saved), .pwm_out(pwm_a),
      .period_strobe(strobe_a));

   pwm_led_bank #(.CHANNELS(C), .DUTY_WIDTH(DW), .PRESCALE(PRESC), .TOP_DEFAULT(8'hff),
                  .ACTIVE_LOW(1'b1), .ADDR_WIDTH(6)) dut_b (
      .fast_clk(fast_clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr),
      .wr_data(wr_data), .rd_data(rd_b), .sel_saved(sel_saved), .pwm_out(pwm_b),
      .period_strobe(strobe_b));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: registers as plain ints, advanced once per clock.
   int           m_cur [C];
   int           m_sav [C];
   int           m_aduty [C];
   int           m_top, m_atop, m_en, m_pcnt, m_psc, m_s1, m_s2;
   logic [C-1:0] m_pwm;
   logic         m_strobe;
   logic [31:0]  m_rd;

   function automatic int m_read(input int a);
      if (a < C) return m_cur[a];
      if (a < 2 * C) return m_sav[a - C];
      if (a == 2 * C) return m_en;
      if (a == 2 * C + 1) return m_top;
      return 0;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < C; i++) begin
         m_cur[i] = 0; m_sav[i] = 0; m_aduty[i] = 0;
      end
      m_top = 255; m_atop = 255; m_en = 1; m_pcnt = 0; m_psc = 0;
      m_s1 = 0; m_s2 = 0; m_pwm = '0; m_strobe = 1'b0; m_rd = '0;
   endtask

   task automatic m_step();
      bit           tick, wrap;
      logic [C-1:0] npwm;
      int           a;
      tick = (m_en != 0) && (m_psc == PRESC - 1);
      wrap = tick && (m_pcnt == m_atop);
      for (int i = 0; i < C; i++) npwm[i] = (m_en != 0) && (m_pcnt < m_aduty[i]);
      m_strobe = wrap;
      if (rd_en) m_rd = 32'(m_read(int'(addr)));
      if (wrap || m_en == 0) begin
         for (int i = 0; i < C; i++) m_aduty[i] = (m_s2 != 0) ? m_sav[i] : m_cur[i];
         m_atop = m_top;
      end
      if (m_en == 0) begin
         m_psc = 0; m_pcnt = 0;
      end else if (tick) begin
         m_psc = 0;
         m_pcnt = wrap ? 0 : m_pcnt + 1;
      end else begin
         m_psc = m_psc + 1;
      end
      m_pwm = npwm;
      m_s2 = m_s1;
      m_s1 = int'(sel_saved);
      if (wr_en) begin
         a = int'(addr);
         if (a < C) m_cur[a] = int'(wr_data[7:0]);
         else if (a < 2 * C) m_sav[a - C] = int'(wr_data[7:0]);
         else if (a == 2 * C) m_en = int'(wr_data[0]);
         else if (a == 2 * C + 1) m_top = int'(wr_data[7:0]);
      end
   endtask

   initial begin
      logic [C-1:0] inv;
      m_reset();
      forever begin
         @(negedge fast_clk);
         if (rst) m_reset();
         inv = ~m_pwm;
         chk("model_pwm_a", 32'(pwm_a), 32'(m_pwm));
         chk("model_pwm_b", 32'(pwm_b), 32'(inv));
         chk("model_strobe_a", 32'(strobe_a), 32'(m_strobe));
         chk("model_strobe_b", 32'(strobe_b), 32'(m_strobe));
         chk("model_rd_a", rd_a, m_rd);
         chk("model_rd_b", rd_b, m_rd);
         if (!rst) m_step();
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   logic [C-1:0] cap_a [4];
   logic [C-1:0] cap_b [4];

   task automatic cyc();
      @(posedge fast_clk);
      #1;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      addr = 6'(a); wr_data = d; wr_en = 1'b1;
      cyc();
      wr_en = 1'b0;
   endtask

   task automatic rd_chk(input string name, input int a, input logic [31:0] exp);
      addr = 6'(a); rd_en = 1'b1;
      cyc();
      rd_en = 1'b0;
      chk(name, rd_a, exp);
   endtask

   task automatic wait_strobe(input int bound);
      bit found = 1'b0;
      for (int k = 0; k < bound; k++) begin
         cyc();
         if (strobe_a) begin
            found = 1'b1;
            break;
         end
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL strobe_timeout no period_strobe within %0d cycles", bound);
      end
   endtask

   task automatic capture();
      for (int j = 0; j < 4; j++) begin
         cyc();
         cap_a[j] = pwm_a;
         cap_b[j] = pwm_b;
      end
   endtask

   function automatic logic [3:0] pat_a(input int ch);
      return {cap_a[0][ch], cap_a[1][ch], cap_a[2][ch], cap_a[3][ch]};
   endfunction

   function automatic logic [3:0] pat_b(input int ch);
      return {cap_b[0][ch], cap_b[1][ch], cap_b[2][ch], cap_b[3][ch]};
   endfunction

   initial begin
      bit seen;
      int n;
      repeat (3) cyc();
      chk("reset_pwm_a", 32'(pwm_a), 32'h00);
      chk("reset_pwm_b", 32'(pwm_b), 32'h3f);
      chk("reset_strobe", 32'(strobe_a), 32'h0);
      chk("reset_rd", rd_a, 32'h0);
      rst = 1'b0;

      // Period of 4 ticks, 50% duty on channel 0.
      wr(13, 32'd3);
      wr(0, 32'd2);
      wait_strobe(300);
      wait_strobe(10);
      capture();
      chk("t1_pattern", 32'(pat_a(0)), 32'b1100);

      // Duty change at pcnt=1 lands at the next wrap.
      cyc();
      wr(0, 32'd1);
      wait_strobe(10);
      capture();
      chk("t2_pattern", 32'(pat_a(0)), 32'b1000);

      // Duty 0 and duty above TOP, both polarities.
      wr(1, 32'd0);
      wr(2, 32'd4);
      wait_strobe(10);
      wait_strobe(10);
      capture();
      chk("t3_ch1_low", 32'(pat_a(1)), 32'b0000);
      chk("t3_ch2_high", 32'(pat_a(2)), 32'b1111);
      chk("t3_ch1_inv", 32'(pat_b(1)), 32'b1111);
      chk("t3_ch2_inv", 32'(pat_b(2)), 32'b0000);

      // Switch to the saved set at pcnt=0.
      wr(6, 32'd3);
      wait_strobe(10);
      sel_saved = 1'b1;
      wait_strobe(10);
      capture();
      chk("t4_saved_pattern", 32'(pat_a(0)), 32'b1110);

      // Disable, then re-enable and count cycles to the first wrap.
      wr(12, 32'd0);
      cyc();
      chk("t5_off_pwm_a", 32'(pwm_a), 32'h00);
      chk("t5_off_pwm_b", 32'(pwm_b), 32'h3f);
      seen = 1'b0;
      repeat (8) begin
         cyc();
         seen |= strobe_a;
      end
      chk("t5_no_strobe", 32'(seen), 32'h0);
      wr(12, 32'd1);
      n = 0;
      for (int k = 0; k < 20; k++) begin
         cyc();
         n++;
         if (strobe_a) break;
      end
      chk("t5_restart_len", 32'(n), 32'd4);

      // Asynchronous reset mid-period.
      cyc();
      cyc();
      rst = 1'b1;
      #1;
      chk("t6_rst_pwm_a", 32'(pwm_a), 32'h00);
      chk("t6_rst_pwm_b", 32'(pwm_b), 32'h3f);
      chk("t6_rst_strobe", 32'(strobe_a), 32'h0);
      sel_saved = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      rd_chk("t6_rd_cur0", 0, 32'h0);
      rd_chk("t6_rd_top", 13, 32'hff);
      rd_chk("t6_rd_unmapped", 14, 32'h0);
      rd_chk("t6_rd_ctrl", 12, 32'h1);
      rd_chk("t6_rd_sav0", 6, 32'h0);

      // Simultaneous write and read returns the old value.
      addr = 6'd3; wr_data = 32'h55; wr_en = 1'b1; rd_en = 1'b1;
      cyc();
      wr_en = 1'b0; rd_en = 1'b0;
      chk("rw_same_cycle", rd_a, 32'h0);
      rd_chk("rw_after", 3, 32'h55);

      wr(4, 32'h1234abcd);
      rd_chk("rd_zero_ext", 4, 32'hcd);
      repeat (3) cyc();
      chk("rd_hold", rd_a, 32'hcd);
      wr(20, 32'hff);
      rd_chk("rd_unmapped_wr", 20, 32'h0);

      repeat (5) cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
